// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, tracks
// outstanding request PCs in a 2-entry tag queue, and buffers up to two
// returned {instr, pc} pairs for the decode stage. A redirect flushes the
// buffer and drains any responses still in flight before fetching again.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic        i_mem_waitreq,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_rdvalid,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_instr,
    output logic [4:0]  o_opcode,
    output logic [15:0] o_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] pc;

    // Output buffer (circular, 2 entries)
    logic [15:0] buf_instr [2];
    logic [15:0] buf_pc    [2];
    logic        buf_head;
    logic [1:0]  buf_cnt;

    // PCs of outstanding requests, oldest at tag_head
    logic [15:0] tag_pc [2];
    logic        tag_head;
    logic [1:0]  tag_cnt;

    // Responses still owed by memory that must be thrown away after a redirect
    logic [1:0]  discard_cnt;

    // A request offered but stalled by waitreq stays asserted until accepted
    logic        req_hold;

    logic        pop;
    logic        accept;
    logic        resp_run;
    logic        resp_any;
    logic        credit_ok;
    logic [2:0]  inflight;
    logic [1:0]  discard_next;
    logic        buf_tail;
    logic        tag_tail;

    // Handshake, credit and index computation
    always_comb begin
        pop          = (buf_cnt != 2'd0) && i_ready;
        // A same-cycle pop frees a slot, which keeps a 1-cycle memory streaming
        credit_ok    = (({1'b0, tag_cnt} + {1'b0, buf_cnt}) - {2'b00, pop}) < 3'd2;
        o_mem_rd     = !reset && (state == RUN) && !i_redirect &&
                       (req_hold || (!i_halt && credit_ok));
        accept       = o_mem_rd && !i_mem_waitreq;
        resp_run     = i_mem_rdvalid && (state == RUN) && (tag_cnt != 2'd0);
        inflight     = {1'b0, tag_cnt} + {1'b0, discard_cnt};
        resp_any     = i_mem_rdvalid && (inflight != 3'd0);
        discard_next = 2'(inflight - {2'b00, resp_any});
        buf_tail     = buf_head ^ buf_cnt[0];
        tag_tail     = tag_head ^ tag_cnt[0];
    end

    assign o_mem_addr = pc;
    assign o_valid    = (buf_cnt != 2'd0);
    assign o_instr    = buf_instr[buf_head];
    assign o_pc       = buf_pc[buf_head];
    assign o_opcode   = o_instr[4:0];

    // Fetch state machine, PC, tag queue and output buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            buf_head     <= 1'b0;
            buf_cnt      <= '0;
            tag_head     <= 1'b0;
            tag_cnt      <= '0;
            discard_cnt  <= '0;
            req_hold     <= 1'b0;
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
            tag_pc[0]    <= '0;
            tag_pc[1]    <= '0;
        end else if (i_redirect) begin
            // Redirect overrides pop, response write and issue in this cycle
            pc          <= i_redirect_pc;
            buf_head    <= 1'b0;
            buf_cnt     <= '0;
            tag_head    <= 1'b0;
            tag_cnt     <= '0;
            req_hold    <= 1'b0;
            discard_cnt <= discard_next;
            state       <= (discard_next != 2'd0) ? DRAIN : RUN;
        end else begin
            req_hold <= o_mem_rd && i_mem_waitreq;

            if (accept) begin
                pc               <= pc + 16'd1;
                tag_pc[tag_tail] <= pc;
            end

            if (resp_run) begin
                buf_instr[buf_tail] <= i_mem_rddata;
                buf_pc[buf_tail]    <= tag_pc[tag_head];
                tag_head            <= ~tag_head;
            end

            if (pop) begin
                buf_head <= ~buf_head;
            end

            case ({accept, resp_run})
                2'b10:   tag_cnt <= tag_cnt + 2'd1;
                2'b01:   tag_cnt <= tag_cnt - 2'd1;
                default: tag_cnt <= tag_cnt;
            endcase

            case ({resp_run, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase

            if ((state == DRAIN) && resp_any) begin
                discard_cnt <= discard_cnt - 2'd1;
                if (discard_cnt == 2'd1) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency in-order memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        i_mem_waitreq;
    logic [15:0] i_mem_rddata;
    logic        i_mem_rdvalid;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_instr;
    logic [4:0]  o_opcode;
    logic [15:0] o_pc;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        i_halt;

    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [4:0]  w_opcode;
    logic [15:0] w_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd      (o_mem_rd),
        .i_mem_waitreq (i_mem_waitreq),
        .i_mem_rddata  (i_mem_rddata),
        .i_mem_rdvalid (i_mem_rdvalid),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_opcode      (o_opcode),
        .o_pc          (o_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_halt        (i_halt)
    );

    // Second instance only exercises PC wrap from 16'hFFFF
    instr_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .o_mem_addr    (w_mem_addr),
        .o_mem_rd      (w_mem_rd),
        .i_mem_waitreq (1'b0),
        .i_mem_rddata  (16'h0000),
        .i_mem_rdvalid (1'b0),
        .o_valid       (w_valid),
        .i_ready       (1'b0),
        .o_instr       (w_instr),
        .o_opcode      (w_opcode),
        .o_pc          (w_pc),
        .i_redirect    (1'b0),
        .i_redirect_pc (16'h0000),
        .i_halt        (1'b0)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } resp_t;

    resp_t       q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_count = 0;
    logic [15:0] last_acc = '1;
    logic        rd_seen;
    logic [15:0] addr_seen;
    logic        inject = 1'b0;
    logic [15:0] inject_data = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present memory response, note request acceptance,
    // then return at the following negedge with outputs settled.
    task automatic tick();
        if (inject) begin
            i_mem_rdvalid = 1'b1;
            i_mem_rddata  = inject_data;
            inject        = 1'b0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            i_mem_rdvalid = 1'b1;
            i_mem_rddata  = 16'h0A00 + q[0].addr;
            void'(q.pop_front());
        end else begin
            i_mem_rdvalid = 1'b0;
            i_mem_rddata  = '0;
        end
        #1;
        rd_seen   = o_mem_rd;
        addr_seen = o_mem_addr;
        if (o_mem_rd && !i_mem_waitreq) begin
            q.push_back('{addr: o_mem_addr, due: cyc + lat});
            acc_count++;
            last_acc = o_mem_addr;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        i_redirect    = 1'b0;
        i_halt        = 1'b0;
        i_mem_waitreq = 1'b0;
        i_mem_rdvalid = 1'b0;
        i_mem_rddata  = '0;
        q.delete();
        acc_count     = 0;
        last_acc      = '1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] e;
        int n;

        reset         = 1'b0;
        i_mem_waitreq = 1'b0;
        i_mem_rddata  = '0;
        i_mem_rdvalid = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_halt        = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 16'(o_valid), 16'h0);
        chk("rst_rd", 16'(o_mem_rd), 16'h0);
        chk("rst_addr", o_mem_addr, 16'h0000);
        chk("rst_instr", o_instr, 16'h0000);
        chk("rst_pc", o_pc, 16'h0000);
        chk("rst_opcode", 16'(o_opcode), 16'h0);
        chk("wrap_rst_addr", w_mem_addr, 16'hFFFF);
        @(negedge clk);
        reset   = 1'b0;
        i_ready = 1'b1;

        // Streaming with 1-cycle memory
        tick();
        chk("first_lat_valid", 16'(o_valid), 16'h0);
        chk("wrap_addr0", w_mem_addr, 16'h0000);
        tick();
        chk("wrap_addr1", w_mem_addr, 16'h0001);
        chk("wrap_rd_stop", 16'(w_mem_rd), 16'h0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            e = 16'h0A00 + 16'(k);
            chk("stream_valid", 16'(o_valid), 16'h1);
            chk("stream_pc", o_pc, 16'(k));
            chk("stream_instr", o_instr, e);
            chk("stream_opcode", 16'(o_opcode), 16'(e[4:0]));
        end

        // Backpressure: buffer fills to 2, then drains in order
        do_reset();
        i_ready = 1'b0;
        repeat (10) tick();
        chk("bp_accepts", 16'(acc_count), 16'd2);
        chk("bp_rd_low", 16'(rd_seen), 16'h0);
        chk("bp_valid", 16'(o_valid), 16'h1);
        chk("bp_pc0", o_pc, 16'h0000);
        chk("bp_instr0", o_instr, 16'h0A00);
        chk("bp_addr", o_mem_addr, 16'h0002);
        i_ready = 1'b1;
        tick();
        chk("bp_pc1", o_pc, 16'h0001);
        chk("bp_instr1", o_instr, 16'h0A01);
        tick();
        chk("bp_valid2", 16'(o_valid), 16'h1);
        chk("bp_pc2", o_pc, 16'h0002);

        // Redirect with two outstanding requests on a 3-cycle memory
        do_reset();
        lat     = 3;
        i_ready = 1'b1;
        n = 0;
        while (last_acc != 16'h0005 && n < 40) begin
            tick();
            n++;
        end
        chk("rdr_reach_pc5", last_acc, 16'h0005);
        chk("rdr_outstanding", 16'(q.size()), 16'd2);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0040;
        tick();
        i_redirect = 1'b0;
        chk("rdr_rd_low", 16'(rd_seen), 16'h0);
        chk("rdr_valid_after", 16'(o_valid), 16'h0);
        tick();
        chk("drain_rd1", 16'(rd_seen), 16'h0);
        tick();
        chk("drain_rd2", 16'(rd_seen), 16'h0);
        tick();
        chk("rdr_restart_rd", 16'(rd_seen), 16'h1);
        chk("rdr_restart_addr", addr_seen, 16'h0040);
        n = 0;
        while (!o_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rdr_valid", 16'(o_valid), 16'h1);
        chk("rdr_pc", o_pc, 16'h0040);
        chk("rdr_instr", o_instr, 16'h0A40);

        // Waitreq stall at address 7
        do_reset();
        lat     = 1;
        i_ready = 1'b1;
        n = 0;
        while (o_mem_addr != 16'h0007 && n < 20) begin
            tick();
            n++;
        end
        chk("stall_reach7", o_mem_addr, 16'h0007);
        i_mem_waitreq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_rd", 16'(rd_seen), 16'h1);
            chk("stall_addr", addr_seen, 16'h0007);
        end
        chk("stall_pc_held", o_mem_addr, 16'h0007);
        i_mem_waitreq = 1'b0;
        tick();
        chk("stall_accept", last_acc, 16'h0007);
        chk("stall_pc_next", o_mem_addr, 16'h0008);
        tick();
        chk("stall_valid", 16'(o_valid), 16'h1);
        chk("stall_out_pc", o_pc, 16'h0007);
        chk("stall_out_instr", o_instr, 16'h0A07);

        // Halt with one request outstanding
        do_reset();
        lat     = 1;
        i_ready = 1'b0;
        tick();
        i_halt = 1'b1;
        tick();
        chk("halt_rd", 16'(rd_seen), 16'h0);
        chk("halt_buffered", 16'(o_valid), 16'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_rd_hold", 16'(rd_seen), 16'h0);
        end
        chk("halt_pc", o_pc, 16'h0000);
        chk("halt_instr", o_instr, 16'h0A00);
        i_halt = 1'b0;
        tick();
        chk("halt_resume_rd", 16'(rd_seen), 16'h1);
        chk("halt_resume_addr", addr_seen, 16'h0001);

        // Reset in the middle of DRAIN, then a stray response
        do_reset();
        lat     = 3;
        i_ready = 1'b1;
        tick();
        tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0100;
        tick();
        i_redirect = 1'b0;
        chk("mrst_redir_pc", o_mem_addr, 16'h0100);
        tick();
        chk("mrst_drain_rd", 16'(rd_seen), 16'h0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_addr", o_mem_addr, 16'h0000);
        chk("mrst_rd", 16'(o_mem_rd), 16'h0);
        chk("mrst_valid", 16'(o_valid), 16'h0);
        q.delete();
        i_mem_rdvalid = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        lat         = 1;
        inject      = 1'b1;
        inject_data = 16'hDEAD;
        tick();
        chk("mrst_restart_rd", 16'(rd_seen), 16'h1);
        chk("mrst_restart_addr", addr_seen, 16'h0000);
        chk("mrst_late_ignored", 16'(o_valid), 16'h0);
        tick();
        chk("mrst_valid0", 16'(o_valid), 16'h1);
        chk("mrst_pc0", o_pc, 16'h0000);
        chk("mrst_instr0", o_instr, 16'h0A00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
